// File: rtl/execute_stage_pkg.sv
// rtl/execute_stage_pkg.sv - opcode constants, ALU op select and NOP word for the execute stage
package execute_stage_pkg;

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BCC   = 7'b1100011;
  localparam logic [6:0] OP_LCC   = 7'b0000011;
  localparam logic [6:0] OP_SCC   = 7'b0100011;
  localparam logic [6:0] OP_MCC   = 7'b0010011;
  localparam logic [6:0] OP_RCC   = 7'b0110011;
  localparam logic [6:0] OP_FCC   = 7'b0001111;
  localparam logic [6:0] OP_CCC   = 7'b1110011;

  // ADDI x0,x0,0 loaded into the X registers on reset
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_SLL,
    ALU_SLT,
    ALU_SLTU,
    ALU_XOR,
    ALU_SRL,
    ALU_SRA,
    ALU_OR,
    ALU_AND,
    ALU_PASSB,
    ALU_ZERO
  } alu_op_t;

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - 32-bit integer ALU; shift amount comes from b[4:0]
module alu
  import execute_stage_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  alu_op_t     op,
  output logic [31:0] result
);

  // select the result for the requested operation, modulo 2^32
  always_comb begin
    result = 32'h0;
    case (op)
      ALU_ADD:   result = a + b;
      ALU_SUB:   result = a - b;
      ALU_SLL:   result = a << b[4:0];
      ALU_SLT:   result = {31'h0, $signed(a) < $signed(b)};
      ALU_SLTU:  result = {31'h0, a < b};
      ALU_XOR:   result = a ^ b;
      ALU_SRL:   result = a >> b[4:0];
      ALU_SRA:   result = $unsigned($signed(a) >>> b[4:0]);
      ALU_OR:    result = a | b;
      ALU_AND:   result = a & b;
      ALU_PASSB: result = b;
      default:   result = 32'h0;
    endcase
  end

endmodule

// File: rtl/execute_stage.sv
// rtl/execute_stage.sv - X-stage pipeline registers, immediate decode, branch compare and ALU steering
module execute_stage
  import execute_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PC_d,
  input  logic [31:0] inst_d,
  input  logic [31:0] rs1_d,
  input  logic [31:0] rs2_d,
  output logic [31:0] PC_x,
  output logic [31:0] inst_x,
  output logic [31:0] rs2_x,
  output logic [31:0] alu_x,
  output logic        PCSel
);

  logic [31:0] rs1_x;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  alu_op_t     alu_op;
  logic [31:0] alu_result;
  logic        clear_lsb;
  logic        br_taken;

  assign opcode = inst_x[6:0];
  assign funct3 = inst_x[14:12];
  assign funct7 = inst_x[31:25];

  // D-to-X pipeline registers; reset loads a NOP and wins over incoming data
  always_ff @(posedge clk) begin
    if (reset) begin
      PC_x   <= 32'h0;
      inst_x <= NOP_INST;
      rs1_x  <= 32'h0;
      rs2_x  <= 32'h0;
    end else begin
      PC_x   <= PC_d;
      inst_x <= inst_d;
      rs1_x  <= rs1_d;
      rs2_x  <= rs2_d;
    end
  end

  // immediate generation by instruction format
  always_comb begin
    imm = 32'h0;
    case (opcode)
      OP_LCC, OP_MCC, OP_JALR: imm = {{20{inst_x[31]}}, inst_x[31:20]};
      OP_SCC:  imm = {{20{inst_x[31]}}, inst_x[31:25], inst_x[11:7]};
      OP_BCC:  imm = {{19{inst_x[31]}}, inst_x[31], inst_x[7], inst_x[30:25], inst_x[11:8], 1'b0};
      OP_JAL:  imm = {{11{inst_x[31]}}, inst_x[31], inst_x[19:12], inst_x[20], inst_x[30:21], 1'b0};
      OP_LUI, OP_AUIPC: imm = {inst_x[31:12], 12'h0};
      default: imm = 32'h0;
    endcase
  end

  // branch condition; the reserved funct3 codes never redirect
  always_comb begin
    br_taken = 1'b0;
    case (funct3)
      3'b000:  br_taken = (rs1_x == rs2_x);
      3'b001:  br_taken = (rs1_x != rs2_x);
      3'b100:  br_taken = ($signed(rs1_x) <  $signed(rs2_x));
      3'b101:  br_taken = ($signed(rs1_x) >= $signed(rs2_x));
      3'b110:  br_taken = (rs1_x <  rs2_x);
      3'b111:  br_taken = (rs1_x >= rs2_x);
      default: br_taken = 1'b0;
    endcase
  end

  // steer ALU operands and decide redirect; anything unrecognised yields zero
  always_comb begin
    alu_a     = rs1_x;
    alu_b     = imm;
    alu_op    = ALU_ZERO;
    PCSel     = 1'b0;
    clear_lsb = 1'b0;
    case (opcode)
      OP_LUI:   alu_op = ALU_PASSB;
      OP_AUIPC: begin alu_a = PC_x; alu_op = ALU_ADD; end
      OP_LCC, OP_SCC: alu_op = ALU_ADD;
      OP_JAL:   begin alu_a = PC_x; alu_op = ALU_ADD; PCSel = 1'b1; end
      OP_JALR:  begin alu_op = ALU_ADD; clear_lsb = 1'b1; PCSel = 1'b1; end
      OP_BCC:   begin alu_a = PC_x; alu_op = ALU_ADD; PCSel = br_taken; end
      OP_MCC: begin
        case (funct3)
          3'b000: alu_op = ALU_ADD;
          3'b010: alu_op = ALU_SLT;
          3'b011: alu_op = ALU_SLTU;
          3'b100: alu_op = ALU_XOR;
          3'b110: alu_op = ALU_OR;
          3'b111: alu_op = ALU_AND;
          3'b001: alu_op = (funct7 == 7'b0000000) ? ALU_SLL : ALU_ZERO;
          default: begin
            if (funct7 == 7'b0000000)      alu_op = ALU_SRL;
            else if (funct7 == 7'b0100000) alu_op = ALU_SRA;
            else                           alu_op = ALU_ZERO;
          end
        endcase
      end
      OP_RCC: begin
        alu_b = rs2_x;
        if (funct7 == 7'b0000000) begin
          case (funct3)
            3'b000:  alu_op = ALU_ADD;
            3'b001:  alu_op = ALU_SLL;
            3'b010:  alu_op = ALU_SLT;
            3'b011:  alu_op = ALU_SLTU;
            3'b100:  alu_op = ALU_XOR;
            3'b101:  alu_op = ALU_SRL;
            3'b110:  alu_op = ALU_OR;
            default: alu_op = ALU_AND;
          endcase
        end else if (funct7 == 7'b0100000) begin
          case (funct3)
            3'b000:  alu_op = ALU_SUB;
            3'b101:  alu_op = ALU_SRA;
            default: alu_op = ALU_ZERO;
          endcase
        end
      end
      OP_FCC, OP_CCC: alu_op = ALU_ZERO;
      default: alu_op = ALU_ZERO;
    endcase
  end

  alu alu (
    .a      (alu_a),
    .b      (alu_b),
    .op     (alu_op),
    .result (alu_result)
  );

  assign alu_x = clear_lsb ? {alu_result[31:1], 1'b0} : alu_result;

endmodule

// File: tb/tb_execute_stage.sv
// tb/tb_execute_stage.sv - directed self-checking bench for execute_stage
module tb_execute_stage;

  logic        clk;
  logic        reset;
  logic [31:0] PC_d;
  logic [31:0] inst_d;
  logic [31:0] rs1_d;
  logic [31:0] rs2_d;
  logic [31:0] PC_x;
  logic [31:0] inst_x;
  logic [31:0] rs2_x;
  logic [31:0] alu_x;
  logic        PCSel;

  int errors = 0;
  int checks = 0;

  execute_stage dut (
    .clk    (clk),
    .reset  (reset),
    .PC_d   (PC_d),
    .inst_d (inst_d),
    .rs1_d  (rs1_d),
    .rs2_d  (rs2_d),
    .PC_x   (PC_x),
    .inst_x (inst_x),
    .rs2_x  (rs2_x),
    .alu_x  (alu_x),
    .PCSel  (PCSel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] enc_i(input logic [11:0] im, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {im, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {f7, rs2, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] im, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3);
    return {im[11:5], rs2, rs1, f3, im[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] im, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3);
    return {im[12], im[10:5], rs2, rs1, f3, im[4:1], im[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:0] im, input logic [4:0] rd);
    return {im[20], im[10:1], im[11], im[19:12], rd, 7'b1101111};
  endfunction

  task automatic step(input logic [31:0] pc, input logic [31:0] inst,
                      input logic [31:0] a, input logic [31:0] b);
    PC_d   = pc;
    inst_d = inst;
    rs1_d  = a;
    rs2_d  = b;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  initial begin
    reset  = 1'b1;
    PC_d   = 32'h0;
    inst_d = 32'h0;
    rs1_d  = 32'h0;
    rs2_d  = 32'h0;
    @(posedge clk);
    step(32'hDEAD_BEEF, 32'hFFFF_FFFF, 32'h1234_5678, 32'h9ABC_DEF0);
    check("rst_pc",    PC_x,   32'h0);
    check("rst_inst",  inst_x, 32'h0000_0013);
    check("rst_rs2",   rs2_x,  32'h0);
    check("rst_alu",   alu_x,  32'h0);
    check("rst_pcsel", {31'h0, PCSel}, 32'h0);
    reset = 1'b0;

    // ADDI x1,x0,-5
    step(32'h0000_0100, enc_i(12'hFFB, 5'd0, 3'b000, 5'd1, 7'b0010011), 32'h0, 32'h0);
    check("addi_inst",   inst_x, 32'hFFB0_0093);
    check("addi_pc",     PC_x,   32'h0000_0100);
    check("addi_opcode", {25'h0, dut.opcode}, 32'h13);
    check("addi_imm",    dut.imm, 32'hFFFF_FFFB);
    check("addi_alu",    alu_x,   32'hFFFF_FFFB);
    check("addi_pcsel",  {31'h0, PCSel}, 32'h0);

    // SUB / SLT / SLTU with rs1=0x80000000, rs2=1
    step(32'h104, enc_r(7'b0100000, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011), 32'h8000_0000, 32'h1);
    check("sub_alu", alu_x, 32'h7FFF_FFFF);
    check("sub_f7",  {25'h0, dut.funct7}, 32'h20);
    step(32'h108, enc_r(7'b0000000, 5'd2, 5'd1, 3'b010, 5'd3, 7'b0110011), 32'h8000_0000, 32'h1);
    check("slt_alu", alu_x, 32'h1);
    step(32'h10C, enc_r(7'b0000000, 5'd2, 5'd1, 3'b011, 5'd3, 7'b0110011), 32'h8000_0000, 32'h1);
    check("sltu_alu", alu_x, 32'h0);

    // SRA / SRL with rs2=0x24 (shamt 4)
    step(32'h110, enc_r(7'b0100000, 5'd2, 5'd1, 3'b101, 5'd3, 7'b0110011), 32'hF000_0000, 32'h24);
    check("sra_alu", alu_x, 32'hFF00_0000);
    step(32'h114, enc_r(7'b0000000, 5'd2, 5'd1, 3'b101, 5'd3, 7'b0110011), 32'hF000_0000, 32'h24);
    check("srl_alu", alu_x, 32'h0F00_0000);

    // RCC with unknown funct7 (0000001) gives zero
    step(32'h118, enc_r(7'b0000001, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011), 32'h5, 32'h6);
    check("badf7_alu", alu_x, 32'h0);

    // BEQ at 0x01000010, imm=-16
    step(32'h0100_0010, enc_b(13'h1FF0, 5'd2, 5'd1, 3'b000), 32'h7, 32'h7);
    check("beq_imm",   dut.imm, 32'hFFFF_FFF0);
    check("beq_alu",   alu_x, 32'h0100_0000);
    check("beq_taken", {31'h0, PCSel}, 32'h1);
    step(32'h0100_0010, enc_b(13'h1FF0, 5'd2, 5'd1, 3'b000), 32'h7, 32'h8);
    check("beq_nt_alu", alu_x, 32'h0100_0000);
    check("beq_nt",     {31'h0, PCSel}, 32'h0);

    // BLT signed taken, BGEU not taken, reserved funct3 never taken
    step(32'h200, enc_b(13'h0008, 5'd2, 5'd1, 3'b100), 32'hFFFF_FFFF, 32'h1);
    check("blt_taken", {31'h0, PCSel}, 32'h1);
    check("blt_alu",   alu_x, 32'h208);
    step(32'h200, enc_b(13'h0008, 5'd2, 5'd1, 3'b111), 32'h1, 32'hFFFF_FFFF);
    check("bgeu_nt", {31'h0, PCSel}, 32'h0);
    step(32'h200, enc_b(13'h0008, 5'd2, 5'd1, 3'b010), 32'h3, 32'h3);
    check("bres_nt", {31'h0, PCSel}, 32'h0);

    // JALR imm=3, rs1=0x01000020
    step(32'h300, enc_i(12'h003, 5'd1, 3'b000, 5'd1, 7'b1100111), 32'h0100_0020, 32'h0);
    check("jalr_alu",   alu_x, 32'h0100_0022);
    check("jalr_pcsel", {31'h0, PCSel}, 32'h1);

    // JAL at 0x01000000, imm=0x800
    step(32'h0100_0000, enc_j(21'h000800, 5'd1), 32'h0, 32'h0);
    check("jal_imm",   dut.imm, 32'h0000_0800);
    check("jal_alu",   alu_x, 32'h0100_0800);
    check("jal_pcsel", {31'h0, PCSel}, 32'h1);

    // LUI, AUIPC
    step(32'h400, {20'h12345, 5'd1, 7'b0110111}, 32'h0, 32'h0);
    check("lui_alu", alu_x, 32'h1234_5000);
    step(32'h0000_1000, {20'h00001, 5'd1, 7'b0010111}, 32'h0, 32'h0);
    check("auipc_alu", alu_x, 32'h0000_2000);

    // SW: address rs1+imm, store data registered
    step(32'h500, enc_s(12'hFFC, 5'd2, 5'd1, 3'b010), 32'h100, 32'hCAFE_F00D);
    check("sw_alu",   alu_x, 32'h0000_00FC);
    check("sw_rs2",   rs2_x, 32'hCAFE_F00D);
    check("sw_pcsel", {31'h0, PCSel}, 32'h0);

    // SRAI by 31, ANDI, SLTIU
    step(32'h600, enc_i(12'h41F, 5'd1, 3'b101, 5'd2, 7'b0010011), 32'h8000_0000, 32'h0);
    check("srai_alu", alu_x, 32'hFFFF_FFFF);
    step(32'h604, enc_i(12'h0FF, 5'd1, 3'b111, 5'd2, 7'b0010011), 32'h0000_F0F0, 32'h0);
    check("andi_alu", alu_x, 32'h0000_00F0);
    step(32'h608, enc_i(12'hFFF, 5'd1, 3'b011, 5'd2, 7'b0010011), 32'h5, 32'h0);
    check("sltiu_alu", alu_x, 32'h1);

    // FENCE gives zero and no redirect
    step(32'h700, enc_i(12'h0FF, 5'd0, 3'b000, 5'd0, 7'b0001111), 32'hFFFF_FFFF, 32'h1);
    check("fcc_alu",   alu_x, 32'h0);
    check("fcc_pcsel", {31'h0, PCSel}, 32'h0);

    // JAL in flight, reset asserted mid-stream discards the incoming instruction
    step(32'h0100_0000, enc_j(21'h000800, 5'd1), 32'h0, 32'h0);
    reset = 1'b1;
    step(32'h0200_0000, enc_j(21'h000800, 5'd1), 32'h55, 32'h66);
    check("mrst_inst",  inst_x, 32'h0000_0013);
    check("mrst_pc",    PC_x,   32'h0);
    check("mrst_alu",   alu_x,  32'h0);
    check("mrst_pcsel", {31'h0, PCSel}, 32'h0);
    reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
